// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: parses a length-prefixed, XOR-checksummed
// byte stream into big-endian words and releases the CPU once the image verifies.
module im_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic [15:0]       n_reg;
  logic [1:0]        lane_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [23:0]       word_reg;
  logic [7:0]        csum_reg;

  logic              in_ready_reg, in_ready_next;
  logic              im_we_reg;
  logic [ADDR_W-1:0] im_waddr_reg;
  logic [31:0]       im_wdata_reg;
  logic              cpu_reset_reg, cpu_reset_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  // The fetch-side base address is documentation for integrators; the loader emits word indices.
  logic [31:0] base_addr_unused;
  assign base_addr_unused = BASE_ADDR;

  logic        accept;
  logic [15:0] n_full;
  logic        n_oversize;
  logic        last_word;

  assign accept     = in_valid && in_ready_reg;
  assign n_full     = {n_reg[15:8], in_data};
  assign n_oversize = {16'd0, n_full} > 32'(DEPTH_WORDS);
  assign last_word  = {{(16-ADDR_W){1'b0}}, idx_reg} == (n_reg - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= HDR0;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR0: if (accept) state_next = HDR1;
      HDR1: if (accept) begin
        if (n_oversize)        state_next = ERR;
        else if (n_full == 16'd0) state_next = CSUM;
        else                   state_next = DATA;
      end
      DATA: if (accept && lane_reg == 2'd3 && last_word) state_next = CSUM;
      CSUM: if (accept) state_next = (in_data == csum_reg) ? RUN : ERR;
      default: state_next = state_reg;
    endcase
  end

  // Status outputs are registered from the upcoming state so they change on the deciding edge.
  always_comb begin
    in_ready_next  = (state_next == HDR0) || (state_next == HDR1) ||
                     (state_next == DATA) || (state_next == CSUM);
    done_next      = (state_next == RUN);
    err_next       = (state_next == ERR);
    cpu_reset_next = (state_next != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg         <= '0;
      lane_reg      <= '0;
      idx_reg       <= '0;
      word_reg      <= '0;
      csum_reg      <= '0;
      in_ready_reg  <= 1'b0;
      im_we_reg     <= 1'b0;
      im_waddr_reg  <= '0;
      im_wdata_reg  <= '0;
      cpu_reset_reg <= 1'b1;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      in_ready_reg  <= in_ready_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      cpu_reset_reg <= cpu_reset_next;
      im_we_reg     <= 1'b0;
      if (accept) begin
        case (state_reg)
          HDR0: n_reg[15:8] <= in_data;
          HDR1: begin
            n_reg[7:0] <= in_data;
            csum_reg   <= '0;
            idx_reg    <= '0;
            lane_reg   <= '0;
          end
          DATA: begin
            word_reg <= {word_reg[15:0], in_data};
            csum_reg <= csum_reg ^ in_data;
            lane_reg <= lane_reg + 2'd1;
            if (lane_reg == 2'd3) begin
              im_we_reg    <= 1'b1;
              im_waddr_reg <= idx_reg;
              im_wdata_reg <= {word_reg, in_data};
              // Holding the index on the final word keeps it within 0..N-1.
              if (!last_word) idx_reg <= idx_reg + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign im_we     = im_we_reg;
  assign im_waddr  = im_waddr_reg;
  assign im_wdata  = im_wdata_reg;
  assign cpu_reset = cpu_reset_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule
